// File: rtl/activation_unit.sv
// Activation-function stage: three-stage pipeline turning accumulator sums into identity,
// ReLU or piecewise-linear activations; non-DATA packets pass through in order.
module activation_unit #(
  parameter int unsigned SSUM_WIDTH = 16,
  parameter int unsigned IN_FRAC    = 8,
  parameter int unsigned OUT_WIDTH  = 8,
  parameter int unsigned OUT_FRAC   = 7,
  parameter int unsigned SEG_BITS   = 3,
  parameter int unsigned RANGE_LOG2 = 3,
  parameter int unsigned COEF_WIDTH = 8,
  parameter int unsigned SLOPE_FRAC = 7,
  parameter int unsigned TYPE_WIDTH = 2,
  parameter int unsigned SEQ_WIDTH  = 8,
  parameter logic [TYPE_WIDTH-1:0] DATA = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hlt,
  input  logic                  ACC_AF_valid,
  input  logic [TYPE_WIDTH-1:0] ACC_AF_type,
  input  logic [SEQ_WIDTH-1:0]  ACC_AF_seqNum,
  input  logic [SSUM_WIDTH-1:0] ACC_AF_data,
  input  logic                  cfg_we,
  input  logic                  cfg_sel,
  input  logic [SEG_BITS-1:0]   cfg_addr,
  input  logic [COEF_WIDTH-1:0] cfg_slope,
  input  logic [OUT_WIDTH-1:0]  cfg_icpt,
  input  logic [1:0]            cfg_mode,
  output logic                  AF_OUT_valid,
  output logic [TYPE_WIDTH-1:0] AF_OUT_type,
  output logic [SEQ_WIDTH-1:0]  AF_OUT_seqNum,
  output logic [OUT_WIDTH-1:0]  AF_OUT_data
);

  localparam int unsigned XCW    = RANGE_LOG2 + IN_FRAC + 1;  // clamped-input width
  localparam int unsigned SH_ID  = IN_FRAC - OUT_FRAC;
  localparam int unsigned SH_PWL = IN_FRAC + SLOPE_FRAC - OUT_FRAC;
  localparam int unsigned MW     = SSUM_WIDTH + COEF_WIDTH + 4;  // wide enough to never wrap
  localparam int unsigned NSEG   = 2 ** SEG_BITS;

  localparam logic signed [SSUM_WIDTH-1:0] XC_MAX =
    {{(SSUM_WIDTH-XCW+1){1'b0}}, {(XCW-1){1'b1}}};
  localparam logic signed [SSUM_WIDTH-1:0] XC_MIN = ~XC_MAX;
  localparam logic signed [XCW-1:0] XC_MAX_N = {1'b0, {(XCW-1){1'b1}}};
  localparam logic signed [XCW-1:0] XC_MIN_N = {1'b1, {(XCW-1){1'b0}}};
  localparam logic signed [MW-1:0] SAT_MAX = {{(MW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [MW-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic signed [MW-1:0] RND_ID  = (SH_ID == 0) ? '0 : (MW'(1) << (SH_ID - 1));
  localparam logic signed [MW-1:0] RND_PWL = (SH_PWL == 0) ? '0 : (MW'(1) << (SH_PWL - 1));

  function automatic logic [OUT_WIDTH-1:0] sat(input logic signed [MW-1:0] v);
    if (v > SAT_MAX) return SAT_MAX[OUT_WIDTH-1:0];
    if (v < SAT_MIN) return SAT_MIN[OUT_WIDTH-1:0];
    return v[OUT_WIDTH-1:0];
  endfunction

  // Config state
  logic signed [COEF_WIDTH-1:0] slope_q [NSEG];
  logic signed [OUT_WIDTH-1:0]  icpt_q  [NSEG];
  logic [1:0]                   mode_q;

  // Stage registers
  logic                         s1_valid_q, s2_valid_q;
  logic [TYPE_WIDTH-1:0]        s1_type_q, s2_type_q;
  logic [SEQ_WIDTH-1:0]         s1_seq_q, s2_seq_q;
  logic signed [SSUM_WIDTH-1:0] s1_data_q, s2_x_q;
  logic signed [XCW-1:0]        s2_xc_q;
  logic [1:0]                   s2_mode_q;
  logic signed [COEF_WIDTH-1:0] s2_slope_q;
  logic signed [OUT_WIDTH-1:0]  s2_icpt_q;

  logic signed [XCW-1:0]        xc;
  logic [SEG_BITS-1:0]          idx;
  logic signed [MW-1:0]         x_w, xc_w, slope_w, icpt_w, id_v, pwl_v;
  logic [OUT_WIDTH-1:0]         y;

  // Table and mode writes; independent of hlt, reset overrides a concurrent write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSEG; i++) begin
        slope_q[i] <= '0;
        icpt_q[i]  <= '0;
      end
      mode_q <= '0;
    end else if (cfg_we) begin
      if (cfg_sel) begin
        mode_q <= cfg_mode;
      end else begin
        slope_q[cfg_addr] <= cfg_slope;
        icpt_q[cfg_addr]  <= cfg_icpt;
      end
    end
  end

  // S1: register the incoming packet
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_type_q  <= '0;
      s1_seq_q   <= '0;
      s1_data_q  <= '0;
    end else if (!hlt) begin
      s1_valid_q <= ACC_AF_valid;
      s1_type_q  <= ACC_AF_type;
      s1_seq_q   <= ACC_AF_seqNum;
      s1_data_q  <= ACC_AF_data;
    end
  end

  // S2 combinational: clamp to the PWL range and pick the segment (offset-binary top bits)
  always_comb begin
    xc = s1_data_q[XCW-1:0];
    if (s1_data_q > XC_MAX) xc = XC_MAX_N;
    else if (s1_data_q < XC_MIN) xc = XC_MIN_N;
    idx = {~xc[XCW-1], xc[XCW-2 -: (SEG_BITS-1)]};
  end

  // S2: capture clamped input, table entry and mode so they travel with the packet
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_type_q  <= '0;
      s2_seq_q   <= '0;
      s2_x_q     <= '0;
      s2_xc_q    <= '0;
      s2_mode_q  <= '0;
      s2_slope_q <= '0;
      s2_icpt_q  <= '0;
    end else if (!hlt) begin
      s2_valid_q <= s1_valid_q;
      s2_type_q  <= s1_type_q;
      s2_seq_q   <= s1_seq_q;
      s2_x_q     <= s1_data_q;
      s2_xc_q    <= xc;
      s2_mode_q  <= mode_q;
      s2_slope_q <= slope_q[idx];
      s2_icpt_q  <= icpt_q[idx];
    end
  end

  // S3 combinational: rounding, multiply-add and saturation per mode
  always_comb begin
    x_w     = {{(MW-SSUM_WIDTH){s2_x_q[SSUM_WIDTH-1]}}, s2_x_q};
    xc_w    = {{(MW-XCW){s2_xc_q[XCW-1]}}, s2_xc_q};
    slope_w = {{(MW-COEF_WIDTH){s2_slope_q[COEF_WIDTH-1]}}, s2_slope_q};
    icpt_w  = {{(MW-OUT_WIDTH){s2_icpt_q[OUT_WIDTH-1]}}, s2_icpt_q};
    id_v    = (x_w + RND_ID) >>> SH_ID;
    pwl_v   = icpt_w + ((xc_w * slope_w + RND_PWL) >>> SH_PWL);
    y       = sat(id_v);
    if (s2_type_q != DATA) begin
      y = s2_x_q[OUT_WIDTH-1:0];
    end else begin
      case (s2_mode_q)
        2'd1:    if (s2_x_q[SSUM_WIDTH-1]) y = '0;
        2'd2:    y = sat(pwl_v);
        default: y = sat(id_v);
      endcase
    end
  end

  // S3: output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      AF_OUT_valid  <= 1'b0;
      AF_OUT_type   <= '0;
      AF_OUT_seqNum <= '0;
      AF_OUT_data   <= '0;
    end else if (!hlt) begin
      AF_OUT_valid  <= s2_valid_q;
      AF_OUT_type   <= s2_type_q;
      AF_OUT_seqNum <= s2_seq_q;
      AF_OUT_data   <= y;
    end
  end

endmodule

// File: tb/tb_activation_unit.sv
// Scoreboard bench for activation_unit: stimulus pushes model results, a monitor pops and checks.
module tb_activation_unit;

  logic       clk = 1'b0;
  logic       rst, hlt;
  logic       ACC_AF_valid;
  logic [1:0] ACC_AF_type;
  logic [7:0] ACC_AF_seqNum;
  logic [15:0] ACC_AF_data;
  logic       cfg_we, cfg_sel;
  logic [2:0] cfg_addr;
  logic [7:0] cfg_slope, cfg_icpt;
  logic [1:0] cfg_mode;
  logic       AF_OUT_valid;
  logic [1:0] AF_OUT_type;
  logic [7:0] AF_OUT_seqNum;
  logic [7:0] AF_OUT_data;

  activation_unit dut (
    .clk(clk), .rst(rst), .hlt(hlt),
    .ACC_AF_valid(ACC_AF_valid), .ACC_AF_type(ACC_AF_type),
    .ACC_AF_seqNum(ACC_AF_seqNum), .ACC_AF_data(ACC_AF_data),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
    .cfg_slope(cfg_slope), .cfg_icpt(cfg_icpt), .cfg_mode(cfg_mode),
    .AF_OUT_valid(AF_OUT_valid), .AF_OUT_type(AF_OUT_type),
    .AF_OUT_seqNum(AF_OUT_seqNum), .AF_OUT_data(AF_OUT_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] typ;
    logic [7:0] seq;
    logic [7:0] data;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   cur_v;
  int   m_slope[8], m_icpt[8], m_mode;
  int   ucnt = 0;
  bit   last_unh = 1'b0;
  int   n_tests = 0, n_fail = 0;

  // Un-halted edge counter: a packet accepted before edge n+1 appears after edge n+3
  always @(posedge clk) begin
    if (!hlt) ucnt <= ucnt + 1;
    last_unh <= !hlt;
  end

  function automatic int rnd(int v, int s);
    return (s == 0) ? v : ((v + (1 << (s - 1))) >>> s);
  endfunction

  function automatic int sat(int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  // Reference activation from the arithmetic definitions
  function automatic logic [7:0] model(int typ, int x);
    int r, xc, idx;
    if (typ != 0) begin
      r = x;
      return r[7:0];
    end
    case (m_mode)
      1: r = (x < 0) ? 0 : sat(rnd(x, 1));
      2: begin
        xc  = (x > 2047) ? 2047 : ((x < -2048) ? -2048 : x);
        idx = (xc + 2048) / 512;
        r   = sat(m_icpt[idx] + rnd(m_slope[idx] * xc, 8));
      end
      default: r = sat(rnd(x, 1));
    endcase
    return r[7:0];
  endfunction

  // One stimulus slot; ck: 0 none, 1 table write (ca, cs, ci), 2 mode write (ca = mode)
  task automatic step(input bit v, input int typ, input int seq, input int x, input bit h,
                      input int ck = 0, input int ca = 0, input int cs = 0, input int ci = 0);
    exp_t e;
    @(posedge clk);
    #2;
    hlt           = h;
    ACC_AF_valid  = v;
    ACC_AF_type   = typ[1:0];
    ACC_AF_seqNum = seq[7:0];
    ACC_AF_data   = x[15:0];
    cfg_we        = (ck != 0);
    cfg_sel       = (ck == 2);
    cfg_addr      = ca[2:0];
    cfg_slope     = cs[7:0];
    cfg_icpt      = ci[7:0];
    cfg_mode      = ca[1:0];
    if (ck == 1) begin
      m_slope[ca] = cs;
      m_icpt[ca]  = ci;
    end else if (ck == 2) begin
      m_mode = ca;
    end
    if (v && !h) begin
      e.cyc  = ucnt + 3;
      e.typ  = typ[1:0];
      e.seq  = seq[7:0];
      e.data = model(typ, x);
      q.push_back(e);
    end
  endtask

  task automatic check_zero(input string name);
    n_tests++;
    if (AF_OUT_valid !== 1'b0 || AF_OUT_type !== 2'd0 || AF_OUT_seqNum !== 8'd0 ||
        AF_OUT_data !== 8'd0) begin
      n_fail++;
      $display("FAIL %s: got v=%b t=%0d s=%0d d=%0h, want all zero", name, AF_OUT_valid,
               AF_OUT_type, AF_OUT_seqNum, AF_OUT_data);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) begin
      m_slope[i] = 0;
      m_icpt[i]  = 0;
    end
    m_mode = 0;
    q.delete();
    cur_v = 1'b0;
  endtask

  // Async reset between edges with a table write pending on the same edge
  task automatic reset_mid();
    @(posedge clk);
    #2;
    hlt = 1'b0; ACC_AF_valid = 1'b0;
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 3'd0; cfg_slope = 8'd100; cfg_icpt = 8'd50;
    #1 rst = 1'b1;
    #1 check_zero("async_reset");
    clear_model();
    @(posedge clk);
    #2 cfg_we = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  // Monitor: on every fresh output compare with the scoreboard head; while halted expect a hold
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (last_unh) begin
          while (q.size() > 0 && q[0].cyc < ucnt) begin
            e = q.pop_front();
            n_tests++; n_fail++;
            $display("FAIL lost seq=%0d: got nothing at cycle %0d, want output", e.seq, e.cyc);
          end
          if (q.size() > 0 && q[0].cyc == ucnt) begin
            e = q.pop_front();
            n_tests++;
            if (AF_OUT_valid !== 1'b1 || AF_OUT_type !== e.typ || AF_OUT_seqNum !== e.seq ||
                AF_OUT_data !== e.data) begin
              n_fail++;
              $display("FAIL out seq=%0d: got v=%b t=%0d s=%0d d=%0h, want v=1 t=%0d s=%0d d=%0h",
                       e.seq, AF_OUT_valid, AF_OUT_type, AF_OUT_seqNum, AF_OUT_data,
                       e.typ, e.seq, e.data);
            end
            cur = e; cur_v = 1'b1;
          end else begin
            n_tests++;
            if (AF_OUT_valid !== 1'b0) begin
              n_fail++;
              $display("FAIL bubble: got v=%b s=%0d, want v=0", AF_OUT_valid, AF_OUT_seqNum);
            end
            cur_v = 1'b0;
          end
        end else begin
          n_tests++;
          if (AF_OUT_valid !== cur_v ||
              (cur_v && (AF_OUT_type !== cur.typ || AF_OUT_seqNum !== cur.seq ||
                         AF_OUT_data !== cur.data))) begin
            n_fail++;
            $display("FAIL hold: got v=%b s=%0d d=%0h, want v=%b s=%0d d=%0h", AF_OUT_valid,
                     AF_OUT_seqNum, AF_OUT_data, cur_v, cur.seq, cur.data);
          end
        end
      end
    end
  end

  initial begin
    int ext[6] = '{-32768, 32767, -2049, 2048, -1, 0};
    int x, typ, ck, ca, cs, ci;
    bit v, h;
    logic signed [15:0] r16;

    rst = 1'b1; hlt = 1'b0; ACC_AF_valid = 1'b0; ACC_AF_type = '0; ACC_AF_seqNum = '0;
    ACC_AF_data = '0; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_slope = '0;
    cfg_icpt = '0; cfg_mode = '0;
    clear_model();
    @(posedge clk);
    #3 check_zero("reset_state");
    @(posedge clk);
    #2 rst = 1'b0;

    // Identity: plain, saturate high/low, rounding
    step(1, 0, 1, 100, 0);
    step(1, 0, 2, 384, 0);
    step(1, 0, 3, -384, 0);
    step(1, 0, 4, 3, 0);
    // ReLU, then four back-to-back packets
    step(0, 0, 0, 0, 0, 2, 1);
    step(1, 0, 5, -300, 0);
    step(1, 0, 6, 100, 0);
    for (int i = 1; i <= 4; i++) step(1, 0, i, 40 * i - 90, 0);
    // PWL table: flat 64 everywhere, entry 4 sloped
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 1, i, 0, 64);
    step(0, 0, 0, 0, 0, 1, 4, 32, 64);
    step(0, 0, 0, 0, 0, 2, 2);
    step(1, 0, 7, 256, 0);
    step(1, 0, 8, -256, 0);
    step(1, 0, 9, 5000, 0);
    // Halt with three packets in flight; inputs offered during halt must be ignored
    step(1, 0, 10, 256, 0);
    step(1, 0, 11, -1000, 0);
    step(1, 0, 12, 1500, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 99, 7, 1);
    step(1, 1, 13, 'h1A5, 0);
    // Table write on the cycle the first packet sits in S2
    step(1, 0, 20, 256, 0);
    step(1, 0, 21, 256, 0, 1, 4, -64, 10);
    step(0, 0, 0, 0, 0);
    // Mid-stream async reset
    step(1, 0, 30, 100, 0);
    step(1, 0, 31, 200, 0);
    reset_mid();
    step(1, 0, 40, 100, 0);
    step(0, 0, 0, 0, 0, 2, 2);
    step(1, 0, 41, -2000, 0);

    // Randomized traffic; config writes only on un-halted slots
    for (int i = 0; i < 400; i++) begin
      h   = ($urandom_range(7, 0) == 0);
      v   = ($urandom_range(3, 0) != 0);
      typ = ($urandom_range(3, 0) == 0) ? int'($urandom_range(3, 1)) : 0;
      case ($urandom_range(3, 0))
        0: begin r16 = 16'($urandom); x = r16; end
        1: x = int'($urandom_range(1000, 0)) - 500;
        2: x = int'($urandom_range(4095, 0)) - 2048;
        default: x = ext[$urandom_range(5, 0)];
      endcase
      ck = 0; ca = 0; cs = 0; ci = 0;
      if (!h && $urandom_range(9, 0) == 0) begin
        ck = ($urandom_range(3, 0) == 0) ? 2 : 1;
        ca = (ck == 2) ? int'($urandom_range(3, 0)) : int'($urandom_range(7, 0));
        cs = int'($urandom_range(255, 0)) - 128;
        ci = int'($urandom_range(255, 0)) - 128;
      end
      step(v, typ, int'($urandom_range(255, 0)), x, h, ck, ca, cs, ci);
    end

    for (int k = 0; k < 20 && q.size() > 0; k++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d outputs outstanding, want 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
